// File: rtl/mul_ppgen_booth4.sv
// Radix-4 Booth partial-product generator: 16 full-width 64-bit rows whose sum mod 2^64 is the product.
// Define PPGEN_REG_STAGE1_EN to register operand preparation (S1); otherwise S1 is combinational.
module mul_ppgen_booth4 #(
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_a,
  input  logic [31:0]        in_b,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1023:0]      pp_flat,
  output logic [1:0]         out_op,
  output logic [TAG_W-1:0]   out_tag
);

  // Unsigned top digit (b unsigned, row 15) spans 0..4 and needs 3A; all other rows are standard Booth.
  function automatic logic [63:0] booth_sel(input logic [2:0] trip, input logic uns_top,
                                            input logic signed [63:0] a64,
                                            input logic signed [63:0] nega,
                                            input logic signed [63:0] threea);
    logic [63:0] r;
    r = '0;
    if (uns_top) begin
      case (trip)
        3'b001, 3'b010: r = a64;
        3'b011, 3'b100: r = a64 <<< 1;
        3'b101, 3'b110: r = threea;
        3'b111:         r = a64 <<< 2;
        default:        r = '0;
      endcase
    end else begin
      case (trip)
        3'b001, 3'b010: r = a64;
        3'b011:         r = a64 <<< 1;
        3'b100:         r = nega <<< 1;
        3'b101, 3'b110: r = nega;
        default:        r = '0;
      endcase
    end
    return r;
  endfunction

  logic                    a_sgn_c;
  logic signed [63:0]      a64_c, nega_c, threea_c;

  logic signed [63:0]      src_a64, src_nega, src_threea;
  logic [31:0]             src_b;
  logic [1:0]              src_op;
  logic [TAG_W-1:0]        src_tag;
  logic                    src_vld;

  logic                    adv_p2;
  logic                    vld_p2_q, vld_p2_d;
  logic [1023:0]           pp_p2_q, pp_p2_d;
  logic [1:0]              op_p2_q, op_p2_d;
  logic [TAG_W-1:0]        tag_p2_q, tag_p2_d;
  logic [32:0]             b_ext;
  logic [1023:0]           rows_c;

  // ---- S1: operand preparation ----
  always_comb begin
    a_sgn_c  = (in_op != 2'b11);
    a64_c    = a_sgn_c ? {{32{in_a[31]}}, in_a} : {32'b0, in_a};
    nega_c   = -a64_c;
    threea_c = a64_c + (a64_c <<< 1);
  end

  assign adv_p2 = !vld_p2_q || out_ready;

`ifdef PPGEN_REG_STAGE1_EN
  logic                    vld_p1_q, vld_p1_d;
  logic signed [63:0]      a64_p1_q, a64_p1_d, nega_p1_q, nega_p1_d, threea_p1_q, threea_p1_d;
  logic [31:0]             b_p1_q, b_p1_d;
  logic [1:0]              op_p1_q, op_p1_d;
  logic [TAG_W-1:0]        tag_p1_q, tag_p1_d;

  assign in_ready = !vld_p1_q || adv_p2;

  always_comb begin
    vld_p1_d    = flush ? 1'b0 : (in_ready ? in_valid : vld_p1_q);
    a64_p1_d    = a64_p1_q;
    nega_p1_d   = nega_p1_q;
    threea_p1_d = threea_p1_q;
    b_p1_d      = b_p1_q;
    op_p1_d     = op_p1_q;
    tag_p1_d    = tag_p1_q;
    if (in_ready && in_valid) begin
      a64_p1_d    = a64_c;
      nega_p1_d   = nega_c;
      threea_p1_d = threea_c;
      b_p1_d      = in_b;
      op_p1_d     = in_op;
      tag_p1_d    = in_tag;
    end
  end

  always_ff @(posedge clk) begin
    a64_p1_q    <= a64_p1_d;
    nega_p1_q   <= nega_p1_d;
    threea_p1_q <= threea_p1_d;
    b_p1_q      <= b_p1_d;
    op_p1_q     <= op_p1_d;
    tag_p1_q    <= tag_p1_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= vld_p1_d;
  end

  assign src_vld    = vld_p1_q;
  assign src_a64    = a64_p1_q;
  assign src_nega   = nega_p1_q;
  assign src_threea = threea_p1_q;
  assign src_b      = b_p1_q;
  assign src_op     = op_p1_q;
  assign src_tag    = tag_p1_q;
`else
  assign in_ready   = adv_p2;
  assign src_vld    = in_valid;
  assign src_a64    = a64_c;
  assign src_nega   = nega_c;
  assign src_threea = threea_c;
  assign src_b      = in_b;
  assign src_op     = in_op;
  assign src_tag    = in_tag;
`endif

  // ---- S2: Booth encoding and row registers ----
  assign b_ext = {src_b, 1'b0};

  always_comb begin
    rows_c = '0;
    for (int i = 0; i < 16; i++) begin
      rows_c[64*i +: 64] = booth_sel(b_ext[2*i+2 -: 3], (i == 15) && src_op[1],
                                     src_a64, src_nega, src_threea) << (2*i);
    end
  end

  always_comb begin
    vld_p2_d = flush ? 1'b0 : (adv_p2 ? src_vld : vld_p2_q);
    pp_p2_d  = pp_p2_q;
    op_p2_d  = op_p2_q;
    tag_p2_d = tag_p2_q;
    if (adv_p2 && src_vld) begin
      pp_p2_d  = rows_c;
      op_p2_d  = src_op;
      tag_p2_d = src_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      pp_p2_q  <= '0;
      op_p2_q  <= '0;
      tag_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p2_d;
      pp_p2_q  <= pp_p2_d;
      op_p2_q  <= op_p2_d;
      tag_p2_q <= tag_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign pp_flat   = pp_p2_q;
  assign out_op    = op_p2_q;
  assign out_tag   = tag_p2_q;

endmodule

// File: tb/tb_mul_ppgen_booth4.sv
// Bench for mul_ppgen_booth4: directed corner cases plus a random stream scored against an arithmetic product model.
module tb_mul_ppgen_booth4;
  localparam int TAG_W = 5;
`ifdef PPGEN_REG_STAGE1_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]       in_a, in_b;
  logic [1:0]        in_op, out_op;
  logic [TAG_W-1:0]  in_tag, out_tag;
  logic [1023:0]     pp_flat;

  typedef struct packed {
    logic [63:0]      prod;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t          sb[$];
  logic [1023:0] last_pp, snap_pp;
  logic [TAG_W-1:0] snap_tag;
  int            compared = 0;
  int            mismatched = 0;

  mul_ppgen_booth4 #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .pp_flat(pp_flat), .out_op(out_op), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic [63:0] ae, be;
    ae = (op != 2'b11 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    be = (op[1] == 1'b0 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    return ae * be;
  endfunction

  function automatic logic [63:0] row_sum(input logic [1023:0] pp);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + pp[64*i +: 64];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs set; scores the coming rising edge and returns at the next falling edge.
  task automatic cycle(output logic acc);
    logic cons;
    exp_t e;
    #1;
    acc  = in_valid && in_ready && !flush && !rst;
    cons = out_valid && out_ready && !rst;
    if (cons) begin
      last_pp = pp_flat;
      if (sb.size() == 0) chk("spurious_out", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("sum", row_sum(pp_flat), e.prod);
        chk("op", 64'(out_op), 64'(e.op));
        chk("tag", 64'(out_tag), 64'(e.tag));
      end
    end
    if (acc) begin
      e.prod = ref_prod(in_a, in_b, in_op);
      e.op   = in_op;
      e.tag  = in_tag;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input logic [TAG_W-1:0] tag);
    logic acc;
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin cycle(acc); n++; end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    int n;
    out_ready = 1'b1; in_valid = 1'b0; n = 0;
    while (sb.size() > 0 && n < 200) begin cycle(acc); n++; end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic acc;
    int k, n, issued;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    last_pp = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_pp_zero", 64'(|pp_flat), 64'd0);
    chk("rst_out_op", 64'(out_op), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    rst = 1'b0;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // MUL signed: -3 * 7
    out_ready = 1'b1; last_pp = '0;
    send(32'hFFFF_FFFD, 32'd7, 2'b00, 5'd1);
    drain();
    chk("mul_row0", last_pp[63:0], 64'h3);
    chk("mul_row1", last_pp[127:64], 64'hFFFF_FFFF_FFFF_FFE8);
    chk("mul_rows_rest", 64'(|last_pp[1023:128]), 64'd0);
    chk("mul_sum", row_sum(last_pp), 64'hFFFF_FFFF_FFFF_FFEB);

    // MULHU all-ones: top digit 2+1+1 = 4 selects 4*A64
    last_pp = '0;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 5'd2);
    drain();
    chk("mulhu_sum", row_sum(last_pp), 64'hFFFF_FFFE_0000_0001);
    chk("mulhu_row15", last_pp[1023:960], (64'd4 * 64'h0000_0000_FFFF_FFFF) << 30);

    // MULHSU and MULH with 0x80000000 operands
    last_pp = '0;
    send(32'h8000_0000, 32'h8000_0000, 2'b10, 5'd3);
    drain();
    chk("mulhsu_sum", row_sum(last_pp), 64'hC000_0000_0000_0000);
    last_pp = '0;
    send(32'h8000_0000, 32'h8000_0000, 2'b01, 5'd4);
    drain();
    chk("mulh_sum", row_sum(last_pp), 64'h4000_0000_0000_0000);

    // Backpressure: three ops with out_ready low
    out_ready = 1'b0; k = 0;
    for (int c = 0; c < 6; c++) begin
      if (k < 3) begin
        in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_op = 2'($urandom_range(0, 3));
        in_tag = TAG_W'(k + 1);
      end else in_valid = 1'b0;
      cycle(acc);
      if (acc) k++;
    end
    chk("bp_accepted", 64'(k), 64'(CAP));
    #1;
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    snap_pp = pp_flat; snap_tag = out_tag;
    @(negedge clk);
    repeat (3) begin cycle(acc); if (acc) k++; end
    chk("bp_pp_stable", 64'(pp_flat === snap_pp), 64'd1);
    chk("bp_tag_stable", 64'(out_tag), 64'(snap_tag));
    chk("bp_first_tag", 64'(out_tag), 64'd1);
    out_ready = 1'b1; n = 0;
    while (k < 3 && n < 20) begin
      in_valid = 1'b1; in_tag = TAG_W'(k + 1);
      cycle(acc);
      if (acc) begin k++; in_a = $urandom; in_b = $urandom; end
      n++;
    end
    chk("bp_all_accepted", 64'(k), 64'd3);
    drain();

    // Asynchronous reset with ops in flight
    out_ready = 1'b0; k = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (k < 2); in_a = $urandom; in_b = $urandom; in_op = 2'b01; in_tag = TAG_W'(10 + k);
      cycle(acc);
      if (acc) k++;
    end
    chk("rstmid_out_valid_before", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_out_valid", 64'(out_valid), 64'd0);
    chk("rstmid_pp_zero", 64'(|pp_flat), 64'd0);
    chk("rstmid_tag_zero", 64'(out_tag), 64'd0);
    sb.delete();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rstmid_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Flush with an op at the input: it must be dropped
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'd5; in_b = 32'd6; in_op = 2'b00; in_tag = 5'd7;
    flush = 1'b1;
    cycle(acc);
    flush = 1'b0; in_valid = 1'b0;
    repeat (4) cycle(acc);
    chk("flush_in_no_out", 64'(out_valid), 64'd0);
    send(32'd9, 32'hFFFF_FFFE, 2'b00, 5'd8);
    drain();

    // Flush with an op already in flight
    out_ready = 1'b0;
    send(32'd11, 32'd13, 2'b11, 5'd9);
    n = 0;
    while (!out_valid && n < 10) begin cycle(acc); n++; end
    chk("flush_pre_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    cycle(acc);
    flush = 1'b0;
    sb.delete();
    chk("flush_cleared", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    send(32'h1234_5678, 32'h8765_4321, 2'b10, 5'd10);
    drain();

    // Random regression
    issued = 0; n = 0; acc = 1'b1;
    while (issued < 10000 && n < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 4) != 0);
        in_a = pick_operand(); in_b = pick_operand();
        in_op = 2'($urandom_range(0, 3)); in_tag = TAG_W'($urandom);
      end
      cycle(acc);
      if (acc) issued++;
      n++;
    end
    chk("rand_issued", 64'(issued), 64'd10000);
    drain();
    chk("final_out_valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
